// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO receiver.
// Define SIPO_RECEIVER_PARITY_EN to expect a trailing even-parity bit after each word.
package sipo_pkg;

  typedef enum logic {IDLE, RECV} sipo_state_t;

  // Count width with headroom for the optional parity bit.
  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

`ifdef SIPO_RECEIVER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/sipo_receiver_if.sv
// Serial input and buffered parallel output bundle of the SIPO receiver.
// SIPO_RECEIVER_PARITY_EN adds the parity_err pulse.
interface sipo_receiver_if #(parameter int N = 8);
  logic         s_in;
  logic         s_valid;
  logic         s_start;
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;
`ifdef SIPO_RECEIVER_PARITY_EN
  logic         parity_err;

  modport slave  (input  s_in, s_valid, s_start, q_ready,
                  output q, q_valid, busy, frame_err, overrun, parity_err);
  modport master (output s_in, s_valid, s_start, q_ready,
                  input  q, q_valid, busy, frame_err, overrun, parity_err);
`else
  modport slave  (input  s_in, s_valid, s_start, q_ready,
                  output q, q_valid, busy, frame_err, overrun);
  modport master (output s_in, s_valid, s_start, q_ready,
                  input  q, q_valid, busy, frame_err, overrun);
`endif
endinterface

// File: rtl/sipo_bit_cnt.sv
// Bit counter for the SIPO receiver: clear, load-1 and increment, with a
// terminal-count flag raised when the last bit of a frame is expected.
module sipo_bit_cnt #(
  parameter int W    = 4,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load1) begin
      cnt_reg <= W'(1);
    end else if (inc) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == W'(LAST));

endmodule

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver with start framing and a one-entry output buffer.
// SIPO_RECEIVER_PARITY_EN: consume a trailing even-parity bit and drop failing words.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  sipo_receiver_if.slave  bus
);

  localparam int CW    = cnt_width(N);
  localparam int FRAME = N + PARITY_BITS;

  sipo_state_t  state_reg, state_next;
  logic [N-1:0] sr_reg, sr_next, sr_shift, sr_first;
  logic [N-1:0] q_reg, q_next, word;
  logic         q_valid_reg, q_valid_next;
  logic         frame_err_reg, frame_err_next;
  logic         overrun_reg, overrun_next;
  logic         cnt_clr, cnt_load1, cnt_inc, cnt_tc;
  logic         done, word_ok, data_bit;
  logic [CW-1:0] cnt;

  sipo_bit_cnt #(.W(CW), .LAST(FRAME - 1)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // sr_shift: register with the new bit shifted in; sr_first: a fresh word holding only the new bit.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign sr_shift[gi] = bus.s_in;
          assign sr_first[gi] = bus.s_in;
        end else begin : g_mv
          assign sr_shift[gi] = sr_reg[gi-1];
          assign sr_first[gi] = 1'b0;
        end
      end else begin : g_lsb
        if (gi == N - 1) begin : g_in
          assign sr_shift[gi] = bus.s_in;
          assign sr_first[gi] = bus.s_in;
        end else begin : g_mv
          assign sr_shift[gi] = sr_reg[gi+1];
          assign sr_first[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // The parity bit, when present, is counted but never shifted into the word.
  assign data_bit = (cnt < CW'(N));

  always_comb begin
    state_next     = state_reg;
    sr_next        = sr_reg;
    cnt_clr        = 1'b0;
    cnt_load1      = 1'b0;
    cnt_inc        = 1'b0;
    done           = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.s_valid && bus.s_start) begin
          sr_next    = sr_first;
          cnt_load1  = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (bus.s_valid) begin
          if (bus.s_start) begin
            sr_next        = sr_first;
            cnt_load1      = 1'b1;
            frame_err_next = 1'b1;
          end else begin
            if (data_bit) sr_next = sr_shift;
            if (cnt_tc) begin
              done       = 1'b1;
              cnt_clr    = 1'b1;
              state_next = IDLE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
    endcase
  end

`ifdef SIPO_RECEIVER_PARITY_EN
  logic parity_err_reg, parity_err_next;
  assign word            = sr_reg;
  assign word_ok         = ~^{sr_reg, bus.s_in};
  assign parity_err_next = done & ~word_ok;
  assign bus.parity_err  = parity_err_reg;
`else
  assign word    = sr_shift;
  assign word_ok = 1'b1;
`endif

  always_comb begin
    q_next       = q_reg;
    q_valid_next = q_valid_reg & ~bus.q_ready;
    overrun_next = 1'b0;
    if (done && word_ok) begin
      if (!q_valid_reg || bus.q_ready) begin
        q_next       = word;
        q_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      sr_reg         <= '0;
      q_reg          <= '0;
      q_valid_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef SIPO_RECEIVER_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sr_reg         <= sr_next;
      q_reg          <= q_next;
      q_valid_reg    <= q_valid_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
`ifdef SIPO_RECEIVER_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign bus.q         = q_reg;
  assign bus.q_valid   = q_valid_reg;
  assign bus.busy      = (state_reg == RECV);
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_sipo_receiver.sv
// Drives an MSB-first and an LSB-first receiver with the same serial stream and
// checks buffered words against a per-receiver expected-word queue.
module tb_sipo_receiver;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sipo_receiver_if #(.N(N)) bm ();
  sipo_receiver_if #(.N(N)) bl ();

  sipo_receiver #(.N(N), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm.slave));
  sipo_receiver #(.N(N), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl.slave));

  int checks = 0;
  int errors = 0;
  int fe_m = 0, fe_l = 0, ov_m = 0, ov_l = 0, pe_m = 0, pe_l = 0;
  logic [N-1:0] exp_m[$];
  logic [N-1:0] exp_l[$];

  always @(posedge clk) begin
    if (bm.frame_err) fe_m++;
    if (bl.frame_err) fe_l++;
    if (bm.overrun)   ov_m++;
    if (bl.overrun)   ov_l++;
`ifdef SIPO_RECEIVER_PARITY_EN
    if (bm.parity_err) pe_m++;
    if (bl.parity_err) pe_l++;
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic v, input logic st);
    bm.s_in = b;  bl.s_in = b;
    bm.s_valid = v; bl.s_valid = v;
    bm.s_start = st; bl.s_start = st;
  endtask

  task automatic set_ready(input logic r);
    bm.q_ready = r;
    bl.q_ready = r;
  endtask

  task automatic send_bit(input logic b, input logic st);
    drive(b, 1'b1, st);
    tick();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Compare the buffered word with the oldest expected word and retire it.
  task automatic pop_check(input string tag);
    check({tag, "_sb_m"}, 32'(exp_m.size() > 0), 32'd1);
    check({tag, "_sb_l"}, 32'(exp_l.size() > 0), 32'd1);
    if (exp_m.size() > 0) check({tag, "_q_m"}, 32'(bm.q), 32'(exp_m.pop_front()));
    if (exp_l.size() > 0) check({tag, "_q_l"}, 32'(bl.q), 32'(exp_l.pop_front()));
  endtask

  task automatic consume(input string tag);
    pop_check(tag);
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    check({tag, "_qv_m_after"}, 32'(bm.q_valid), 32'd0);
    check({tag, "_qv_l_after"}, 32'(bl.q_valid), 32'd0);
  endtask

  // Send w MSB-first (plus parity when enabled). Gaps put junk on s_in/s_start with s_valid=0.
  task automatic send_word(input logic [N-1:0] w, input bit gaps, input bit ready_last,
                           input bit push, input bit par_flip);
    logic bits[$];
    for (int i = N - 1; i >= 0; i--) bits.push_back(w[i]);
`ifdef SIPO_RECEIVER_PARITY_EN
    bits.push_back((^w) ^ par_flip);
`endif
    if (push) begin
      exp_m.push_back(w);
      exp_l.push_back(rev(w));
    end
    for (int k = 0; k < bits.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
          tick();
        end
      end
      if (ready_last && k == bits.size() - 1) begin
        pop_check("handoff");
        set_ready(1'b1);
      end
      send_bit(bits[k], k == 0);
      set_ready(1'b0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_q_m"},  32'(bm.q), 32'd0);
    check({tag, "_q_l"},  32'(bl.q), 32'd0);
    check({tag, "_qv_m"}, 32'(bm.q_valid), 32'd0);
    check({tag, "_qv_l"}, 32'(bl.q_valid), 32'd0);
    check({tag, "_busy"}, 32'({bm.busy, bl.busy}), 32'd0);
    check({tag, "_pulses"}, 32'({bm.frame_err, bl.frame_err, bm.overrun, bl.overrun}), 32'd0);
  endtask

  int fe0, ov0, pe0;

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_ready(1'b0);
    repeat (2) tick();
    check_idle("in_reset");
    reset = 1'b1;
    tick();
    check_idle("after_reset");
    $display("reset: outputs cleared");

    // MSB-first 8'hA5 (palindrome, so both receivers see A5)
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_qv_m", 32'(bm.q_valid), 32'd1);
    check("a5_qv_l", 32'(bl.q_valid), 32'd1);
    check("a5_idle", 32'({bm.busy, bl.busy}), 32'd0);
    consume("a5");
    $display("word 0xa5: delivered");

    // Stream 1,1,0,0,0,0,0,0: 0xC0 MSB-first, 0x03 LSB-first
    send_word(8'hC0, 1'b0, 1'b0, 1'b1, 1'b0);
    consume("c0");
    send_word(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    consume("c0_gaps");
    $display("stream 11000000: delivered with and without gaps");

    // Three bits then an early start: abort and restart with 0x3C
    fe0 = fe_m;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("abort_busy", 32'({bm.busy, bl.busy}), 32'b11);
    send_word(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_fe_m", 32'(fe_m - fe0), 32'd1);
    check("abort_fe_l", 32'(fe_l - fe0), 32'd1);
    consume("3c");
    $display("early start: frame_err pulsed, word 0x3c delivered");

    // Back-to-back with consumer stalled: second word is dropped
    ov0 = ov_m;
    send_word(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("ovr_m", 32'(ov_m - ov0), 32'd1);
    check("ovr_l", 32'(ov_l - ov0), 32'd1);
    consume("ovr_held");
    $display("overrun: 0x22 dropped, 0x11 held");

    // Same pair, consumer accepts on the completion edge: no bubble, no overrun
    ov0 = ov_m;
    send_word(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_qv_m", 32'(bm.q_valid), 32'd1);
    check("b2b_qv_l", 32'(bl.q_valid), 32'd1);
    tick();
    check("b2b_ovr", 32'((ov_m - ov0) + (ov_l - ov0)), 32'd0);
    consume("b2b");
    $display("back-to-back: 0x22 replaced 0x11 without overrun");

    // Async reset with a buffered word and a partial word in flight
    send_word(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("pre_rst_busy", 32'({bm.busy, bl.busy}), 32'b11);
    check("pre_rst_qv", 32'({bm.q_valid, bl.q_valid}), 32'b11);
    #2;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    exp_m.delete();
    exp_l.delete();
    tick();
    reset = 1'b1;
    tick();
    $display("mid-word reset: cleared immediately");

`ifdef SIPO_RECEIVER_PARITY_EN
    pe0 = pe_m;
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_ok_qv", 32'({bm.q_valid, bl.q_valid}), 32'b11);
    consume("par_ok");
    send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("par_bad_pe_m", 32'(pe_m - pe0), 32'd1);
    check("par_bad_pe_l", 32'(pe_l - pe0), 32'd1);
    check("par_bad_qv", 32'({bm.q_valid, bl.q_valid}), 32'd0);
    $display("parity: good word accepted, bad word dropped");
`else
    pe0 = 0;
    check("no_parity_pe", 32'(pe_m + pe_l + pe0), 32'd0);
`endif

    check("sb_empty", 32'(exp_m.size() + exp_l.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_receiver.md
Name: sipo_receiver

Overview:
Serial-in, parallel-out receiver for the serial side of the shift-register datapath. Collects N bits from a strobed serial stream, framed by a start marker, and assembles them into a word. Presents each completed word on a one-entry output buffer with a valid/ready handshake. Flags mid-word resynchronisation and overruns.

Parameters:
N, 8, word width in bits (N >= 2)
MSB_FIRST, 1, 1: first received bit lands in q[N-1]; 0: first bit lands in q[0]

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
s_in  input  1  serial data bit
s_valid  input  1  s_in is valid this cycle
s_start  input  1  qualifies s_valid; marks the first bit of a word
q  output  N  assembled parallel word
q_valid  output  1  q holds an unconsumed word
q_ready  input  1  consumer accepts q this cycle (when q_valid=1)
busy  output  1  word reception in progress (state RECV)
frame_err  output  1  one-cycle pulse: word aborted by an early s_start
overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full

Behaviour:
- Reset (reset=0, async): state=IDLE, bit count=0, shift reg=0, q=0, q_valid=0, busy=0, frame_err=0, overrun=0.
- A bit is accepted only on a clock edge where s_valid=1. s_start without s_valid is ignored.
- IDLE:
  - s_valid&s_start: capture the bit as bit 0, count=1, go to RECV.
  - s_valid&!s_start: bit discarded, stay in IDLE.
- RECV:
  - s_valid&!s_start: shift the bit in, count+1.
  - On the Nth bit (count==N-1 before the edge): word complete; go to IDLE, count=0.
  - s_valid&s_start with count<N: partial word discarded, frame_err=1 for one cycle, this bit becomes bit 0 (count=1), stay in RECV.
- Shift direction:
  - MSB_FIRST=1: sr <= {sr[N-2:0], s_in}.
  - MSB_FIRST=0: sr <= {s_in, sr[N-1:1]}.
- Completion latency: q/q_valid update on the same edge that accepts the last bit, so they are visible in the following cycle.
- Handshake:
  - Transfer occurs when q_valid&q_ready.
  - q is stable while q_valid=1 and no transfer occurs.
  - q_valid deasserts after a transfer unless a new word completes on that same edge.
- Completion with q_valid=0, or q_valid&q_ready on the same edge: q <= new word, q_valid=1 (back-to-back, no bubble).
- Completion with q_valid&!q_ready: new word dropped, q unchanged, overrun=1 for one cycle.
- Simultaneous early s_start and completion is impossible: the Nth bit always completes the word, and s_start on that Nth bit is treated as an abort.
- Gaps (s_valid=0) may occur anywhere inside a word. They do not time out.
- busy=1 exactly while in RECV.
- Reset mid-word or with q_valid=1: everything clears and the buffered word is lost.

Optional Feature:
Macro SIPO_RECEIVER_PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit (the N+1th accepted bit), which the receiver consumes.
  - The word is written to the buffer only if XOR(word, parity bit)=0. Otherwise it is dropped and parity_err (extra output, 1 bit) pulses for one cycle.
  - Overrun is evaluated only for words that pass parity.
  - Completion latency is counted from the parity bit.
- Undefined: no parity bit and no parity_err port; words complete on the Nth bit.

Decomposition:
- Package sipo_pkg:
  - typedef enum logic {IDLE, RECV} sipo_state_t
  - function for the bit-count width: $clog2(N+2)
  - localparam PARITY_BITS (0 or 1, set from the macro)
- One sub-module, sipo_bit_cnt: the counter with clear, load-1 and increment, plus a terminal-count output. Shift register, FSM and output buffer stay in sipo_receiver.

Test Plan:
- Reset held low 2 cycles, then released → all outputs 0, busy=0. Assert reset again while busy=1 → immediate clear.
- N=8, MSB_FIRST=1: send bits 1,0,1,0,0,1,0,1 with s_start on the first bit, q_ready=0 → q=8'hA5, q_valid=1 one cycle after the 8th bit. Pulse q_ready → q_valid=0.
- MSB_FIRST=0: same bit stream → q=8'hA5 bit-reversed (8'hA5 is a palindrome, so use stream 1,1,0,0,0,0,0,0) → q=8'h03. Add random s_valid gaps → same q.
- Send 3 bits, then s_start with a new word 8'h3C → frame_err pulses once, q=8'h3C, no extra q_valid.
- Two back-to-back words 8'h11, 8'h22 with q_ready=0 → q=8'h11 held, overrun pulses once at the 2nd completion. Repeat with q_ready=1 on the completion edge → q=8'h22, q_valid stays 1, no overrun.
- With SIPO_RECEIVER_PARITY_EN: 8'hA5 plus parity 0 → accepted. 8'hA5 plus parity 1 → parity_err pulse, q_valid stays 0.
